// File: rtl/psx_pad_decoder.sv
// psx_pad_decoder
// Consumer stage for the dual PSX controller poller. On DataReady, walks both
// controllers' byte buffers in parallel, validates each frame, decodes buttons
// and steering into active-high player inputs, releases the poller with a
// one-cycle read_burst, and marks a pad stale after STALE_FRAMES vsync edges
// without a valid frame.
// Optional build macro: PAD_DEADZONE_EN (forces small analog steer to 0).
module psx_pad_decoder #(
  parameter int unsigned STALE_FRAMES = 8,
  parameter int unsigned DEADZONE     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        DataReady,
  input  logic [7:0]  ControllerByte1,
  input  logic [7:0]  ControllerByte2,
  output logic [3:0]  ByteAddress1,
  output logic [3:0]  ByteAddress2,
  output logic        read_burst,
  output logic [15:0] p1_buttons,
  output logic [15:0] p2_buttons,
  output logic [15:0] p1_press,
  output logic [15:0] p2_press,
  output logic [7:0]  p1_steer,
  output logic [7:0]  p2_steer,
  output logic        p1_analog,
  output logic        p2_analog,
  output logic        p1_valid,
  output logic        p2_valid,
  output logic        update
);

  typedef enum logic [1:0] {IDLE, FETCH, COMMIT, RELEASE} state_t;

`ifdef PAD_DEADZONE_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif
  localparam int         DZ        = int'(DEADZONE);
  localparam logic [2:0] LAST_SLOT = 3'd5;

  // Shadow slot order: 0 ID, 1 sync (0x5A), 2 buttons lo, 3 buttons hi, 4 LX, 5 LY
  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  shadow [2][6];
  logic        vs_q;

  logic [15:0] btn_q    [2];
  logic [15:0] press_q  [2];
  logic [7:0]  steer_q  [2];
  logic [7:0]  cnt_q    [2];
  logic        analog_q [2];
  logic        valid_q  [2];

  logic        vs_rise;
  logic        commit_ok [2];
  logic        stale_hit [2];
  logic [15:0] btn_new   [2];
  logic [7:0]  steer_new [2];
  logic [7:0]  cnt_inc   [2];

  function automatic logic [3:0] slot_addr(input logic [2:0] s);
    case (s)
      3'd0:    slot_addr = 4'd1;
      3'd1:    slot_addr = 4'd2;
      3'd2:    slot_addr = 4'd3;
      3'd3:    slot_addr = 4'd4;
      3'd4:    slot_addr = 4'd7;
      3'd5:    slot_addr = 4'd8;
      default: slot_addr = 4'd0;
    endcase
  endfunction

  function automatic logic frame_ok(input logic [7:0] id, input logic [7:0] sync);
    return ((id == 8'h41) || (id == 8'h73)) && (sync == 8'h5A);
  endfunction

  // Analog: LX offset-binary to two's complement, -128 folded to -127.
  // Digital: Left/Right d-pad bits are active-low in the raw byte.
  function automatic logic [7:0] steer_of(input logic [7:0] id, input logic [7:0] b3,
                                          input logic [7:0] lx);
    logic [7:0]        u;
    logic signed [7:0] s;
    logic              left;
    logic              right;
    if (id == 8'h73) begin
      u = lx ^ 8'h80;
      if (u == 8'h80) u = 8'h81;
      s = $signed(u);
      if (DZ_EN && (int'(s) > -DZ) && (int'(s) < DZ)) s = 8'sd0;
      return s;
    end
    left  = ~b3[7];
    right = ~b3[5];
    if (left && !right) return 8'h81;
    if (right && !left) return 8'h7F;
    return 8'h00;
  endfunction

  // Decode the captured frame and the next stale-counter value per pad
  always_comb begin
    vs_rise = vsync & ~vs_q;
    for (int unsigned p = 0; p < 2; p++) begin
      btn_new[p]   = ~{shadow[p][3], shadow[p][2]};
      steer_new[p] = steer_of(shadow[p][0], shadow[p][2], shadow[p][4]);
      commit_ok[p] = (state == COMMIT) && frame_ok(shadow[p][0], shadow[p][1]);
      cnt_inc[p]   = (vs_rise && (cnt_q[p] != 8'hFF)) ? cnt_q[p] + 8'd1 : cnt_q[p];
      stale_hit[p] = (32'(cnt_inc[p]) >= STALE_FRAMES);
    end
  end

  // Sequencer, shadow capture and registered player outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      vs_q         <= 1'b0;
      ByteAddress1 <= '0;
      ByteAddress2 <= '0;
      read_burst   <= 1'b0;
      update       <= 1'b0;
      for (int unsigned p = 0; p < 2; p++) begin
        for (int unsigned s = 0; s < 6; s++) shadow[p][s] <= '0;
        btn_q[p]    <= '0;
        press_q[p]  <= '0;
        steer_q[p]  <= '0;
        cnt_q[p]    <= '0;
        analog_q[p] <= 1'b0;
        valid_q[p]  <= 1'b0;
      end
    end else begin
      vs_q       <= vsync;
      read_burst <= 1'b0;
      update     <= 1'b0;

      case (state)
        IDLE: begin
          idx <= '0;
          if (DataReady) begin
            state        <= FETCH;
            ByteAddress1 <= slot_addr(3'd0);
            ByteAddress2 <= slot_addr(3'd0);
          end
        end
        FETCH: begin
          // Address was registered last edge, so the byte has settled a full cycle
          shadow[0][idx] <= ControllerByte1;
          shadow[1][idx] <= ControllerByte2;
          if (idx == LAST_SLOT) begin
            state        <= COMMIT;
            idx          <= '0;
            ByteAddress1 <= '0;
            ByteAddress2 <= '0;
          end else begin
            idx          <= idx + 3'd1;
            ByteAddress1 <= slot_addr(idx + 3'd1);
            ByteAddress2 <= slot_addr(idx + 3'd1);
          end
        end
        COMMIT: begin
          read_burst <= 1'b1;
          update     <= 1'b1;
          state      <= RELEASE;
        end
        RELEASE: begin
          if (!DataReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A valid commit beats a coincident vsync edge; stale zeroing otherwise wins
      for (int unsigned p = 0; p < 2; p++) begin
        press_q[p] <= '0;
        if (commit_ok[p]) begin
          btn_q[p]    <= btn_new[p];
          press_q[p]  <= btn_new[p] & ~btn_q[p];
          steer_q[p]  <= steer_new[p];
          analog_q[p] <= (shadow[p][0] == 8'h73);
          valid_q[p]  <= 1'b1;
          cnt_q[p]    <= '0;
        end else begin
          cnt_q[p] <= cnt_inc[p];
          if (stale_hit[p]) begin
            btn_q[p]    <= '0;
            steer_q[p]  <= '0;
            analog_q[p] <= 1'b0;
            valid_q[p]  <= 1'b0;
          end
        end
      end
    end
  end

  assign p1_buttons = btn_q[0];
  assign p2_buttons = btn_q[1];
  assign p1_press   = press_q[0];
  assign p2_press   = press_q[1];
  assign p1_steer   = steer_q[0];
  assign p2_steer   = steer_q[1];
  assign p1_analog  = analog_q[0];
  assign p2_analog  = analog_q[1];
  assign p1_valid   = valid_q[0];
  assign p2_valid   = valid_q[1];

endmodule

// File: tb/tb_psx_pad_decoder.sv
// Self-checking bench for psx_pad_decoder: behavioural model plus literal pins.
module tb_psx_pad_decoder;

  localparam int STALE    = 8;
  localparam int DEADZONE = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        DataReady = 1'b0;
  logic [7:0]  ControllerByte1, ControllerByte2;
  logic [3:0]  ByteAddress1, ByteAddress2;
  logic        read_burst, update;
  logic [15:0] p1_buttons, p2_buttons, p1_press, p2_press;
  logic [7:0]  p1_steer, p2_steer;
  logic        p1_analog, p2_analog, p1_valid, p2_valid;

  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  // Model state
  logic [15:0] m_btn [2];
  logic [15:0] m_press [2];
  logic [7:0]  m_steer [2];
  logic        m_an [2];
  logic        m_val [2];
  int          m_cnt [2];
  logic        m_rb = 1'b0, m_upd = 1'b0, m_vsq = 1'b0;
  logic [3:0]  m_addr = '0;
  int          m_k = 0;
  bit          m_rel = 1'b0;

  psx_pad_decoder #(.STALE_FRAMES(STALE), .DEADZONE(DEADZONE)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .DataReady(DataReady),
    .ControllerByte1(ControllerByte1), .ControllerByte2(ControllerByte2),
    .ByteAddress1(ByteAddress1), .ByteAddress2(ByteAddress2),
    .read_burst(read_burst),
    .p1_buttons(p1_buttons), .p2_buttons(p2_buttons),
    .p1_press(p1_press), .p2_press(p2_press),
    .p1_steer(p1_steer), .p2_steer(p2_steer),
    .p1_analog(p1_analog), .p2_analog(p2_analog),
    .p1_valid(p1_valid), .p2_valid(p2_valid),
    .update(update)
  );

  assign ControllerByte1 = mem1[ByteAddress1];
  assign ControllerByte2 = mem2[ByteAddress2];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] tbl(input int i);
    int a [6] = '{1, 2, 3, 4, 7, 8};
    return 4'(a[i]);
  endfunction

  function automatic logic [7:0] rd(input int p, input int a);
    return (p == 0) ? mem1[a] : mem2[a];
  endfunction

  function automatic logic [7:0] mdl_steer(input logic [7:0] id, input logic [7:0] b3,
                                           input logic [7:0] lx);
    int v;
    if (id == 8'h73) begin
      v = int'(lx) - 128;
      if (v < -127) v = -127;
`ifdef PAD_DEADZONE_EN
      if (v > -DEADZONE && v < DEADZONE) v = 0;
`endif
    end else begin
      v = (b3[7] ? 0 : -127) + (b3[5] ? 0 : 127);
    end
    return 8'(v);
  endfunction

  task automatic set_frame(input int p, input logic [7:0] id, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4,
                           input logic [7:0] lx, input logic [7:0] ly);
    if (p == 0) begin
      mem1[1] = id; mem1[2] = b2; mem1[3] = b3; mem1[4] = b4; mem1[7] = lx; mem1[8] = ly;
    end else begin
      mem2[1] = id; mem2[2] = b2; mem2[3] = b3; mem2[4] = b4; mem2[7] = lx; mem2[8] = ly;
    end
  endtask

  // Behavioural model: a transfer commits on the 7th edge after DataReady is
  // accepted; stale counters follow vsync rising edges.
  initial begin : model
    bit rise;
    bit ok [2];
    logic [15:0] nb;
    for (int p = 0; p < 2; p++) begin
      m_btn[p] = '0; m_press[p] = '0; m_steer[p] = '0; m_an[p] = 0; m_val[p] = 0; m_cnt[p] = 0;
    end
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_k = 0; m_rel = 0; m_vsq = 0; m_rb = 0; m_upd = 0; m_addr = '0;
        for (int p = 0; p < 2; p++) begin
          m_btn[p] = '0; m_press[p] = '0; m_steer[p] = '0; m_an[p] = 0; m_val[p] = 0; m_cnt[p] = 0;
        end
      end else begin
        m_rb = 0; m_upd = 0; ok[0] = 0; ok[1] = 0;
        m_press[0] = '0; m_press[1] = '0;
        rise = vsync && !m_vsq;
        m_vsq = vsync;
        if (m_rel) begin
          if (!DataReady) m_rel = 0;
        end else if (m_k == 0) begin
          if (DataReady) begin m_k = 1; m_addr = tbl(0); end
        end else if (m_k < 6) begin
          m_addr = tbl(m_k); m_k++;
        end else if (m_k == 6) begin
          m_addr = '0; m_k = 7;
        end else begin
          m_rb = 1; m_upd = 1; m_k = 0; m_rel = 1;
          for (int p = 0; p < 2; p++) begin
            if ((rd(p, 1) == 8'h41 || rd(p, 1) == 8'h73) && rd(p, 2) == 8'h5A) begin
              ok[p] = 1;
              nb = ~{rd(p, 4), rd(p, 3)};
              m_press[p] = nb & ~m_btn[p];
              m_btn[p] = nb;
              m_an[p] = (rd(p, 1) == 8'h73);
              m_steer[p] = mdl_steer(rd(p, 1), rd(p, 3), rd(p, 7));
              m_val[p] = 1;
              m_cnt[p] = 0;
            end
          end
        end
        for (int p = 0; p < 2; p++) begin
          if (!ok[p]) begin
            if (rise && m_cnt[p] < 255) m_cnt[p]++;
            if (m_cnt[p] >= STALE) begin
              m_btn[p] = '0; m_steer[p] = '0; m_an[p] = 0; m_val[p] = 0;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      if (cmp_en) begin
        chk("addr1", 16'(ByteAddress1), 16'(m_addr));
        chk("addr2", 16'(ByteAddress2), 16'(m_addr));
        chk("read_burst", 16'(read_burst), 16'(m_rb));
        chk("update", 16'(update), 16'(m_upd));
        chk("p1_buttons", p1_buttons, m_btn[0]);
        chk("p2_buttons", p2_buttons, m_btn[1]);
        chk("p1_press", p1_press, m_press[0]);
        chk("p2_press", p2_press, m_press[1]);
        chk("p1_steer", 16'(p1_steer), 16'(m_steer[0]));
        chk("p2_steer", 16'(p2_steer), 16'(m_steer[1]));
        chk("p1_analog", 16'(p1_analog), 16'(m_an[0]));
        chk("p2_analog", 16'(p2_analog), 16'(m_an[1]));
        chk("p1_valid", 16'(p1_valid), 16'(m_val[0]));
        chk("p2_valid", 16'(p2_valid), 16'(m_val[1]));
      end
    end
  end

  // One transfer; returns at the negedge where read_burst is first seen high
  task automatic xfer(input bit vs_commit, input bit drop_early);
    int n;
    @(negedge clk);
    DataReady = 1'b1;
    n = 0;
    while (!read_burst && n < 20) begin
      @(negedge clk);
      n++;
      if (drop_early && n == 2) DataReady = 1'b0;
      if (vs_commit && n == 7) vsync = 1'b1;
    end
    vsync = 1'b0;
    DataReady = 1'b0;
    chk("burst_latency", 16'(n - 1), 16'd7);
  endtask

  task automatic vs_pulses(input int n);
    repeat (n) begin
      @(negedge clk); vsync = 1'b1;
      @(negedge clk); vsync = 1'b0;
    end
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < 16; i++) begin mem1[i] = 8'hFF; mem2[i] = 8'hFF; end
    #2 rst = 1'b0;
    cmp_en = 1'b1;
    settle(3);
    #1;
    chk("rst_p1_valid", 16'(p1_valid), 16'd0);
    chk("rst_read_burst", 16'(read_burst), 16'd0);
    rst = 1'b1;
    settle(2);

    // Analog P1, digital P2 with Left
    set_frame(0, 8'h73, 8'h5A, 8'hFF, 8'hBF, 8'hC0, 8'h80);
    set_frame(1, 8'h41, 8'h5A, 8'h7F, 8'hFF, 8'h00, 8'h00);
    xfer(0, 0);
    #1;
    chk("A_p1_buttons", p1_buttons, 16'h4000);
    chk("A_p1_press", p1_press, 16'h4000);
    chk("A_p1_steer", 16'(p1_steer), 16'h0040);
    chk("A_p1_analog", 16'(p1_analog), 16'd1);
    chk("A_p2_buttons", p2_buttons, 16'h0080);
    chk("A_p2_steer", 16'(p2_steer), 16'h0081);
    settle(1);
    #1;
    chk("A_p1_press_off", p1_press, 16'h0000);
    settle(2);

    // P2 Left+Right cancel
    set_frame(1, 8'h41, 8'h5A, 8'h5F, 8'hFF, 8'h00, 8'h00);
    xfer(0, 0);
    #1;
    chk("B_p2_steer", 16'(p2_steer), 16'h0000);
    chk("B_p2_press", p2_press, 16'h0020);
    chk("B_p1_press", p1_press, 16'h0000);
    settle(3);

    // Invalid P1 frame holds, P2 still updates
    set_frame(0, 8'h73, 8'h00, 8'hFF, 8'hFF, 8'h10, 8'h80);
    set_frame(1, 8'h41, 8'h5A, 8'hFF, 8'hFF, 8'h00, 8'h00);
    xfer(0, 0);
    #1;
    chk("C_p1_hold", p1_buttons, 16'h4000);
    chk("C_p1_press", p1_press, 16'h0000);
    chk("C_p1_steer", 16'(p1_steer), 16'h0040);
    chk("C_p2_steer", 16'(p2_steer), 16'h0000);
    settle(3);

    // Near-centre analog; DataReady drops during the fetch
    set_frame(0, 8'h73, 8'h5A, 8'hFF, 8'hFF, 8'h8A, 8'h80);
    xfer(0, 1);
    #1;
`ifdef PAD_DEADZONE_EN
    chk("D_p1_steer_dz", 16'(p1_steer), 16'h0000);
`else
    chk("D_p1_steer", 16'(p1_steer), 16'h000A);
`endif
    settle(3);

    // Full-left analog with a vsync edge on the commit edge
    set_frame(0, 8'h73, 8'h5A, 8'hFF, 8'hBF, 8'h00, 8'h80);
    xfer(1, 0);
    #1;
    chk("E_p1_steer", 16'(p1_steer), 16'h0081);
    settle(2);
    vs_pulses(STALE - 1);
    chk("S_p1_alive", 16'(p1_valid), 16'd1);
    vs_pulses(1);
    chk("S_p1_stale", 16'(p1_valid), 16'd0);
    chk("S_p1_buttons", p1_buttons, 16'h0000);
    chk("S_p1_steer", 16'(p1_steer), 16'h0000);
    chk("S_p2_stale", 16'(p2_valid), 16'd0);
    settle(2);
    xfer(0, 0);
    #1;
    chk("F_p1_valid", 16'(p1_valid), 16'd1);
    chk("F_p1_press", p1_press, 16'h4000);
    settle(3);

    // Asynchronous reset in the middle of a fetch
    set_frame(0, 8'h73, 8'h5A, 8'hFF, 8'hBF, 8'hC0, 8'h80);
    @(negedge clk);
    DataReady = 1'b1;
    settle(3);
    rst = 1'b0;
    #1;
    chk("R_p1_buttons", p1_buttons, 16'h0000);
    chk("R_addr1", 16'(ByteAddress1), 16'h0000);
    chk("R_p1_valid", 16'(p1_valid), 16'd0);
    DataReady = 1'b0;
    settle(2);
    rst = 1'b1;
    settle(10);
    xfer(0, 0);
    #1;
    chk("G_p1_press", p1_press, 16'h4000);
    settle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/psx_pad_decoder.md
# psx_pad_decoder

Consumer stage for the dual PSX controller poller. When the poller raises `DataReady`, this block walks both controllers' byte buffers through `ByteAddress1`/`ByteAddress2` and validates each frame. It then decodes buttons and steering into active-high game inputs for both players, releases the poller with a one-cycle `read_burst`, and flags a pad stale if no valid frame has arrived for several video frames.

## Interface
- `STALE_FRAMES`, 8: vsync rising edges without a valid frame before `pN_valid` drops (1..255).
- `DEADZONE`, 16: analog steer magnitude forced to 0 (only with `PAD_DEADZONE_EN`).
- `clk` in 1: system clock, shared with the poller.
- `rst` in 1: reset, asynchronous, active-low.
- `vsync` in 1: frame sync, synchronous to `clk`.
- `DataReady` in 1: poller buffers complete.
- `ControllerByte1`/`ControllerByte2` in 8: byte at the current address, controller 1/2, combinational.
- `ByteAddress1`/`ByteAddress2` out 4: registered byte address, controller 1/2.
- `read_burst` out 1: one-cycle release pulse to the poller.
- `p1_buttons`/`p2_buttons` out 16: active-high buttons, `{byte4, byte3}` inverted.
- `p1_press`/`p2_press` out 16: one-cycle rising-edge pulses of the buttons.
- `p1_steer`/`p2_steer` out 8: signed steering, -127..+127.
- `p1_analog`/`p2_analog` out 1: last valid frame was analog (ID 0x73).
- `p1_valid`/`p2_valid` out 1: pad alive and not stale.
- `update` out 1: one-cycle strobe when outputs are committed.

## Operation
- States: IDLE, FETCH, COMMIT, RELEASE.
- IDLE -> FETCH:
  - Trigger: `DataReady`=1.
  - Address index loads 0; both addresses are driven from the table {1,2,3,4,7,8} (ID, 0x5A, buttons lo, buttons hi, LX, LY).
- FETCH:
  - On each edge, capture both `ControllerByteN` into shadow slot[index] and advance index.
  - After slot 5 is captured, go to COMMIT.
  - Both controllers are fetched in parallel.
- Frame validity, per pad: ID in {0x41, 0x73} and byte2 == 0x5A.
- COMMIT, per pad:
  - If the frame is valid:
    - `pN_buttons` = ~{b4,b3}.
    - `pN_press` = new & ~old.
    - `pN_analog` = (ID == 0x73).
    - Stale counter clears; `pN_valid` = 1.
  - If the frame is invalid: that pad's outputs hold and `pN_press` = 0.
  - `read_burst` = 1 and `update` = 1 for this cycle; then go to RELEASE.
- RELEASE: wait for `DataReady`=0, then go to IDLE. This prevents re-reading the same frame.
- Steer, analog: s = LX ^ 0x80 (LX-128 as signed); -128 clamps to -127.
- Steer, digital (ID 0x41): Left (bit7 of byte3) only -> -127; Right (bit5) only -> +127; both or none -> 0. LX/LY are ignored.
- Stale detection:
  - Per pad, an 8-bit counter increments on each `vsync` rising edge and saturates.
  - When it reaches `STALE_FRAMES`: `pN_valid` = 0; buttons, steer and analog = 0; press = 0.
  - A vsync edge in the same cycle as a valid COMMIT loses; the counter is cleared.
- Addresses hold at 0 outside FETCH.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, vsync edge register 0.
- Latency from `DataReady` sampled high to the `read_burst` pulse is 7 cycles: 6 FETCH + 1 COMMIT.
- An address is registered at edge k and its data is captured at edge k+1. Each byte therefore has one full cycle to settle.
- `read_burst`, `update` and `pN_press` are exactly one cycle wide and coincide.
- `DataReady` falling during FETCH: the fetch completes and COMMIT proceeds. RELEASE then exits on the next cycle.
- Asynchronous reset mid-FETCH aborts the fetch; shadow slots are discarded and no `read_burst` is issued.

## Configuration
- `PAD_DEADZONE_EN` defined: analog steer with |s| < `DEADZONE` becomes 0. Digital steer is unaffected.
- `PAD_DEADZONE_EN` undefined: analog steer passes through after the -128 clamp only. The `DEADZONE` parameter is ignored.

## Test plan
- Analog pad: P1 bytes ID=0x73, 0x5A, b3=0xFF, b4=0xBF (Cross), LX=0xC0, LY=0x80 -> `p1_buttons`=0x4000, `p1_press`=0x4000 for one cycle, `p1_steer`=+64, `p1_analog`=1, `read_burst` 7 cycles after `DataReady`.
- Digital pad: P2 ID=0x41, b3=0x7F (Left) -> `p2_steer`=-127. With b3=0x5F (Left+Right) -> `p2_steer`=0.
- Invalid frame: P1 byte2=0x00 -> P1 outputs hold, `p1_press`=0. P2 updates normally; `read_burst` still pulses.
- Stale: no `DataReady` for 8 vsync pulses -> `pN_valid`=0 and outputs zero on the 8th edge. The next valid frame restores them.
- Deadzone: with `PAD_DEADZONE_EN`, LX=0x8A -> steer 0; without it -> +10. LX=0x00 -> -127 in both builds.
- Reset: assert `rst`=0 mid-FETCH -> outputs 0 immediately and no `read_burst`. After release, the next `DataReady` starts a clean fetch.
